// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Optional static branch prediction is enabled by defining FETCH_PREDICT_BTFN_EN.
module fetch_stage #(
   parameter int unsigned RESET_PC_W = 64,
   parameter int unsigned INSTR_W    = 32
) (
   input  logic                  CLK,
   input  logic                  Reset_L,
   input  logic [RESET_PC_W-1:0] startPC,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [RESET_PC_W-1:0] redirectPC,
   output logic [RESET_PC_W-1:0] iMemAddr,
   input  logic [INSTR_W-1:0]    iMemData,
   output logic [RESET_PC_W-1:0] FetchedPC,
   output logic [RESET_PC_W-1:0] ifid_pc,
   output logic [INSTR_W-1:0]    ifid_instr,
   output logic                  ifid_valid,
   output logic                  ifid_predTaken,
   output logic [31:0]           fetchCount
);

   logic [RESET_PC_W-1:0] pc_q;
   logic [RESET_PC_W-1:0] ifid_pc_q;
   logic [INSTR_W-1:0]    ifid_instr_q;
   logic                  ifid_valid_q;
   logic                  ifid_pred_q;
   logic [31:0]           fetch_count_q;

   logic [RESET_PC_W-1:0] next_pc;
   logic                  pred_taken;

`ifdef FETCH_PREDICT_BTFN_EN
   logic                  is_b;
   logic                  is_cb_back;
   logic [RESET_PC_W-1:0] b_off;
   logic [RESET_PC_W-1:0] cb_off;

   // B/BL always taken; CBZ/CBNZ taken only when the offset is negative (backward).
   always_comb begin
      is_b       = (iMemData[31:26] == 6'b000101) || (iMemData[31:26] == 6'b100101);
      is_cb_back = (iMemData[31:25] == 7'b1011010) && iMemData[23];
      b_off      = {{(RESET_PC_W - 28){iMemData[25]}}, iMemData[25:0], 2'b00};
      cb_off     = {{(RESET_PC_W - 21){iMemData[23]}}, iMemData[23:5], 2'b00};
      pred_taken = is_b || is_cb_back;
      next_pc    = pc_q + RESET_PC_W'(4);
      if (is_b) begin
         next_pc = pc_q + b_off;
      end else if (is_cb_back) begin
         next_pc = pc_q + cb_off;
      end
   end
`else
   always_comb begin
      pred_taken = 1'b0;
      next_pc    = pc_q + RESET_PC_W'(4);
   end
`endif

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         pc_q          <= startPC;
         ifid_pc_q     <= '0;
         ifid_instr_q  <= '0;
         ifid_valid_q  <= 1'b0;
         ifid_pred_q   <= 1'b0;
         fetch_count_q <= '0;
      end else if (redirect) begin
         // Redirect wins over stall so a resolved branch is never lost.
         pc_q          <= redirectPC;
         ifid_valid_q  <= 1'b0;
         ifid_pred_q   <= 1'b0;
      end else if (!stall) begin
         pc_q          <= next_pc;
         ifid_pc_q     <= pc_q;
         ifid_instr_q  <= iMemData;
         ifid_valid_q  <= 1'b1;
         ifid_pred_q   <= pred_taken;
         fetch_count_q <= fetch_count_q + 32'd1;
      end
   end

   assign iMemAddr       = pc_q;
   assign FetchedPC      = pc_q;
   assign ifid_pc        = ifid_pc_q;
   assign ifid_instr     = ifid_instr_q;
   assign ifid_valid     = ifid_valid_q;
   assign ifid_predTaken = ifid_pred_q;
   assign fetchCount     = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural fetch model compared every cycle,
// plus directed checks with literal expectations.
module tb_fetch_stage;

`ifdef FETCH_PREDICT_BTFN_EN
   localparam bit PRED = 1'b1;
`else
   localparam bit PRED = 1'b0;
`endif

   logic        CLK;
   logic        Reset_L;
   logic [63:0] startPC;
   logic        stall;
   logic        redirect;
   logic [63:0] redirectPC;
   logic [63:0] iMemAddr;
   logic [31:0] iMemData;
   logic [63:0] FetchedPC;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic        ifid_predTaken;
   logic [31:0] fetchCount;

   int total = 0;
   int bad   = 0;

   fetch_stage #(.RESET_PC_W(64), .INSTR_W(32)) dut (
      .CLK            (CLK),
      .Reset_L        (Reset_L),
      .startPC        (startPC),
      .stall          (stall),
      .redirect       (redirect),
      .redirectPC     (redirectPC),
      .iMemAddr       (iMemAddr),
      .iMemData       (iMemData),
      .FetchedPC      (FetchedPC),
      .ifid_pc        (ifid_pc),
      .ifid_instr     (ifid_instr),
      .ifid_valid     (ifid_valid),
      .ifid_predTaken (ifid_predTaken),
      .fetchCount     (fetchCount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Instruction memory contents: a few branches, everything else an ADD-class word.
   function automatic logic [31:0] imem(input logic [63:0] a);
      case (a)
         64'h100: return 32'h17FF_FFFE;  // B, imm26 = -2
         64'h020: return 32'hB500_0060;  // CBNZ, imm19 = +3
         64'h200: return 32'hB4FF_FFE0;  // CBZ, imm19 = -1
         default: return 32'h8B00_0000 ^ {8'h00, a[23:0]};
      endcase
   endfunction

   assign iMemData = imem(iMemAddr);

   function automatic logic is_uncond(input logic [31:0] w);
      return (w[31:26] == 6'b000101) || (w[31:26] == 6'b100101);
   endfunction

   function automatic logic is_back_cb(input logic [31:0] w);
      return (w[31:25] == 7'b1011010) && ($signed(w[23:5]) < 0);
   endfunction

   function automatic logic pred_bit(input logic [31:0] w);
      return PRED && (is_uncond(w) || is_back_cb(w));
   endfunction

   function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [31:0] w);
      longint off;
      off = 4;
      if (PRED && is_uncond(w)) off = longint'($signed(w[25:0])) * 4;
      else if (PRED && is_back_cb(w)) off = longint'($signed(w[23:5])) * 4;
      return pc + 64'(off);
   endfunction

   // Behavioural model of the architectural state after each edge.
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_instr, m_cnt;
   logic        m_valid, m_pred;
   logic        m_known = 1'b0;

   always @(posedge CLK) begin
      if (!Reset_L) begin
         m_pc    <= startPC;
         m_ipc   <= '0;
         m_instr <= '0;
         m_valid <= 1'b0;
         m_pred  <= 1'b0;
         m_cnt   <= '0;
         m_known <= 1'b1;
      end else if (redirect) begin
         m_pc    <= redirectPC;
         m_valid <= 1'b0;
         m_pred  <= 1'b0;
      end else if (!stall) begin
         m_pc    <= model_next(m_pc, imem(m_pc));
         m_ipc   <= m_pc;
         m_instr <= imem(m_pc);
         m_valid <= 1'b1;
         m_pred  <= pred_bit(imem(m_pc));
         m_cnt   <= m_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (m_known) begin
         chk("model FetchedPC", FetchedPC, m_pc);
         chk("model iMemAddr", iMemAddr, m_pc);
         chk("model ifid_valid", 64'(ifid_valid), 64'(m_valid));
         chk("model ifid_predTaken", 64'(ifid_predTaken), 64'(m_pred));
         chk("model fetchCount", 64'(fetchCount), 64'(m_cnt));
         if (m_valid) begin
            chk("model ifid_pc", ifid_pc, m_ipc);
            chk("model ifid_instr", 64'(ifid_instr), 64'(m_instr));
         end
      end
   end

   task automatic redirect_to(input logic [63:0] a);
      redirect   = 1'b1;
      redirectPC = a;
      @(negedge CLK);
      redirect   = 1'b0;
   endtask

   logic [19:0] stall_pat;

   initial begin
      Reset_L    = 1'b0;
      startPC    = 64'h40;
      stall      = 1'b0;
      redirect   = 1'b0;
      redirectPC = '0;
      repeat (5) @(negedge CLK);
      chk("reset FetchedPC", FetchedPC, 64'h40);
      chk("reset ifid_valid", 64'(ifid_valid), 64'd0);
      chk("reset fetchCount", 64'(fetchCount), 64'd0);
      chk("reset ifid_pc", ifid_pc, 64'd0);

      Reset_L = 1'b1;
      @(negedge CLK);
      chk("first FetchedPC", FetchedPC, 64'h44);
      chk("first ifid_pc", ifid_pc, 64'h40);
      chk("first ifid_instr", 64'(ifid_instr), 64'h8B00_0040);
      chk("first ifid_valid", 64'(ifid_valid), 64'd1);
      chk("first fetchCount", 64'(fetchCount), 64'd1);

      // Stall with PC=0x10 and a valid 0x0C held in IF/ID.
      redirect_to(64'h0C);
      @(negedge CLK);
      stall = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("stall FetchedPC", FetchedPC, 64'h10);
         chk("stall ifid_pc", ifid_pc, 64'h0C);
         chk("stall ifid_valid", 64'(ifid_valid), 64'd1);
         chk("stall fetchCount", 64'(fetchCount), 64'd2);
      end
      stall = 1'b0;
      @(negedge CLK);
      chk("resume FetchedPC", FetchedPC, 64'h14);
      chk("resume ifid_pc", ifid_pc, 64'h10);
      chk("resume fetchCount", 64'(fetchCount), 64'd3);

      // Redirect beats stall.
      stall = 1'b1;
      redirect_to(64'hA0);
      chk("redir FetchedPC", FetchedPC, 64'hA0);
      chk("redir ifid_valid", 64'(ifid_valid), 64'd0);
      chk("redir fetchCount", 64'(fetchCount), 64'd3);
      stall = 1'b0;
      @(negedge CLK);
      chk("target ifid_pc", ifid_pc, 64'hA0);
      chk("target ifid_valid", 64'(ifid_valid), 64'd1);
      chk("target FetchedPC", FetchedPC, 64'hA4);

      // Unconditional branch backward.
      redirect_to(64'h100);
      @(negedge CLK);
      chk("B FetchedPC", FetchedPC, PRED ? 64'hF8 : 64'h104);
      chk("B predTaken", 64'(ifid_predTaken), PRED ? 64'd1 : 64'd0);
      chk("B ifid_instr", 64'(ifid_instr), 64'h17FF_FFFE);

      // Forward CBNZ is never predicted.
      redirect_to(64'h20);
      @(negedge CLK);
      chk("CBNZ FetchedPC", FetchedPC, 64'h24);
      chk("CBNZ predTaken", 64'(ifid_predTaken), 64'd0);
      chk("CBNZ fetchCount", 64'(fetchCount), 64'd6);

      // PC wraparound.
      redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
      @(negedge CLK);
      chk("wrap FetchedPC", FetchedPC, 64'd0);
      chk("wrap ifid_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // Reset wins over redirect.
      startPC    = 64'd0;
      Reset_L    = 1'b0;
      redirect   = 1'b1;
      redirectPC = 64'h80;
      @(negedge CLK);
      chk("rst>redir FetchedPC", FetchedPC, 64'd0);
      chk("rst>redir ifid_valid", 64'(ifid_valid), 64'd0);
      chk("rst>redir fetchCount", 64'(fetchCount), 64'd0);
      Reset_L  = 1'b1;
      redirect = 1'b0;

      // Free run through a backward CBZ with an irregular stall pattern.
      redirect_to(64'h1F8);
      stall_pat = 20'b0110_0010_1000_0011_0100;
      for (int i = 0; i < 20; i++) begin
         stall = stall_pat[i];
         @(negedge CLK);
      end
      stall = 1'b0;
      repeat (4) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
